// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - funct and shifter control encodings shared by the shift issue stage
package shift_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  localparam logic [1:0] ALUC_SRA = 2'b00;
  localparam logic [1:0] ALUC_SRL = 2'b01;
  localparam logic [1:0] ALUC_SLL = 2'b10;

endpackage

// File: rtl/barrelshifter32.sv
// rtl/barrelshifter32.sv - combinational 32-bit barrel shifter (aluc 00=SRA, 01=SRL, 1x=SLL)
module barrelshifter32 (
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic [1:0]  aluc,
  output logic [31:0] c
);

  logic [31:0] stage;

  // Log-depth shifter: stage i shifts by 2^i when b[i] is set.
  always_comb begin
    stage = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) begin
        if (aluc[1]) begin
          stage = stage << (1 << i);
        end else if (aluc[0]) begin
          stage = stage >> (1 << i);
        end else begin
          stage = $signed(stage) >>> (1 << i);
        end
      end
    end
    c = stage;
  end

endmodule

// File: rtl/shift_decode.sv
// rtl/shift_decode.sv - decodes an R-type shift instruction into barrel shifter controls
module shift_decode
  import shift_pkg::*;
(
  input  logic [5:0]  funct_i,
  input  logic [4:0]  shamt_i,
  input  logic [4:0]  rs_amt_i,
  input  logic [31:0] rt_val_i,
  output logic [31:0] a_o,
  output logic [4:0]  b_o,
  output logic [1:0]  aluc_o,
  output logic        err_o
);

  always_comb begin
    a_o    = rt_val_i;
    b_o    = shamt_i;
    aluc_o = ALUC_SLL;
    err_o  = 1'b0;
    case (funct_i)
      FUNCT_SLL: begin
        b_o    = shamt_i;
        aluc_o = ALUC_SLL;
      end
      FUNCT_SRL: begin
        b_o    = shamt_i;
        aluc_o = ALUC_SRL;
      end
      FUNCT_SRA: begin
        b_o    = shamt_i;
        aluc_o = ALUC_SRA;
      end
      FUNCT_SLLV: begin
        b_o    = rs_amt_i;
        aluc_o = ALUC_SLL;
      end
      FUNCT_SRLV: begin
        b_o    = rs_amt_i;
        aluc_o = ALUC_SRL;
      end
      FUNCT_SRAV: begin
        b_o    = rs_amt_i;
        aluc_o = ALUC_SRA;
      end
      default: begin
        // Non-shift ops still flow through the pipe so retirement stays in order.
        a_o    = '0;
        b_o    = '0;
        aluc_o = ALUC_SRA;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - two-stage issue/retire pipeline around an external barrel shifter
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  output logic [31:0]      sh_a,
  output logic [4:0]       sh_b,
  output logic [1:0]       sh_aluc,
  input  logic [31:0]      sh_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      dec_a;
  logic [4:0]       dec_b;
  logic [1:0]       dec_aluc;
  logic             dec_err;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_err_q, s1_err_d;
  logic [31:0]      sh_a_q, sh_a_d;
  logic [4:0]       sh_b_q, sh_b_d;
  logic [1:0]       sh_aluc_q, sh_aluc_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic             s2_adv;
  logic             accept;
  logic             retire;
  logic             unused_rs_hi;

  // Only the low five bits of rs form a variable shift amount.
  assign unused_rs_hi = ^rs_val[31:5];

  shift_decode u_decode (
    .funct_i  (funct),
    .shamt_i  (shamt),
    .rs_amt_i (rs_val[4:0]),
    .rt_val_i (rt_val),
    .a_o      (dec_a),
    .b_o      (dec_b),
    .aluc_o   (dec_aluc),
    .err_o    (dec_err)
  );

  assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;
  assign retire   = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_err_d   = s1_err_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    sh_aluc_d  = sh_aluc_q;
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    done_cnt_d = done_cnt_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_err_d   = dec_err;
      sh_a_d     = dec_a;
      sh_b_d     = dec_b;
      sh_aluc_d  = dec_aluc;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    // sh_c is a pure function of the S1 registers, so it is sampled as S1 moves on.
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      out_data_d = s1_err_q ? 32'h0 : sh_c;
      out_err_d  = s1_err_q;
    end else if (retire) begin
      s2_valid_d = 1'b0;
    end

    if (retire) begin
      done_cnt_d = done_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      sh_aluc_q  <= ALUC_SRA;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      sh_aluc_q  <= sh_aluc_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign sh_a      = sh_a_q;
  assign sh_b      = sh_b_q;
  assign sh_aluc   = sh_aluc_q;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - scoreboard bench for shift_issue_stage with barrelshifter32
module tb_shift_issue_stage;

  localparam int          CW = 6;
  localparam logic [31:0] RT = 32'hA5F0C3E7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    funct = '0;
  logic [4:0]    shamt = '0;
  logic [31:0]   rs_val = '0;
  logic [31:0]   rt_val = '0;
  logic [31:0]   sh_a;
  logic [4:0]    sh_b;
  logic [1:0]    sh_aluc;
  logic [31:0]   sh_c;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          out_err;
  logic [CW-1:0] done_cnt;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [32:0]   sb[$];
  logic [31:0]   retired = 0;
  logic          hold_q = 1'b0;
  logic [31:0]   hold_data = '0;
  logic          hold_err = 1'b0;

  always #5 clk = ~clk;

  shift_issue_stage #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct     (funct),
    .shamt     (shamt),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .sh_a      (sh_a),
    .sh_b      (sh_b),
    .sh_aluc   (sh_aluc),
    .sh_c      (sh_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .done_cnt  (done_cnt)
  );

  barrelshifter32 u_bs (
    .a    (sh_a),
    .b    (sh_b),
    .aluc (sh_aluc),
    .c    (sh_c)
  );

  // Reference result {err, data} straight from the instruction semantics.
  function automatic logic [32:0] model(input logic [5:0] f, input logic [4:0] sa,
                                        input logic [31:0] rs, input logic [31:0] rt);
    int unsigned       amt;
    logic signed [31:0] srt;
    srt = rt;
    amt = rs % 32;
    case (f)
      6'b000000: return {1'b0, rt << sa};
      6'b000010: return {1'b0, rt >> sa};
      6'b000011: return {1'b0, 32'(srt >>> sa)};
      6'b000100: return {1'b0, rt << amt};
      6'b000110: return {1'b0, rt >> amt};
      6'b000111: return {1'b0, 32'(srt >>> amt)};
      default:   return {1'b1, 32'h0};
    endcase
  endfunction

  always @(posedge rst) begin
    sb.delete();
    retired = 0;
    hold_q  = 1'b0;
  end

  always @(negedge clk) begin
    logic [32:0] exp_r;
    if (!rst) begin
      n_checks++;
      if (done_cnt !== retired[CW-1:0])
        $display("FAIL done_cnt: got %0d want %0d", done_cnt, retired[CW-1:0]);
      else n_pass++;
      if (hold_q) begin
        n_checks++;
        if ({out_err, out_data} !== {hold_err, hold_data})
          $display("FAIL stall_hold: got %h want %h", {out_err, out_data}, {hold_err, hold_data});
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_output: got %h want none", {out_err, out_data});
        end else begin
          exp_r = sb.pop_front();
          if ({out_err, out_data} !== exp_r)
            $display("FAIL retire_data: got %h want %h", {out_err, out_data}, exp_r);
          else n_pass++;
        end
        retired++;
      end
      if (in_valid && in_ready) sb.push_back(model(funct, shamt, rs_val, rt_val));
      hold_q    = out_valid && !out_ready;
      hold_data = out_data;
      hold_err  = out_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [5:0] f, input logic [4:0] sa,
                        input logic [31:0] rs, input logic [31:0] rt);
    in_valid = v;
    funct    = f;
    shamt    = sa;
    rs_val   = rs;
    rt_val   = rt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_op(1'b0, 6'd0, 5'd0, 32'h0, 32'h0);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (done_cnt !== '0) $display("FAIL rst_done_cnt: got %0d want 0", done_cnt); else n_pass++;
    n_checks++; if (sh_a !== 32'h0) $display("FAIL rst_sh_a: got %h want 0", sh_a); else n_pass++;
    n_checks++; if (sh_b !== 5'h0) $display("FAIL rst_sh_b: got %h want 0", sh_b); else n_pass++;
    n_checks++; if (sh_aluc !== 2'b00) $display("FAIL rst_sh_aluc: got %b want 00", sh_aluc); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (out_err !== 1'b0) $display("FAIL rst_out_err: got %b want 0", out_err); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_single_ops();
    logic [5:0]  fs [5] = '{6'b000011, 6'b000010, 6'b000000, 6'b000111, 6'b000100};
    logic [4:0]  sas[5] = '{5'd4, 5'd4, 5'd4, 5'd9, 5'd7};
    logic [31:0] rss[5] = '{32'h0, 32'h0, 32'h0, 32'h00000024, 32'h0};
    logic [31:0] exs[5] = '{32'hFA5F0C3E, 32'h0A5F0C3E, 32'h5F0C3E70, 32'hFA5F0C3E, 32'hA5F0C3E7};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_op(1'b1, fs[k], sas[k], rss[k], RT);
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL single_in_ready[%0d]: got %b want 1", k, in_ready); else n_pass++;
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL single_early[%0d]: got %b want 0", k, out_valid); else n_pass++;
      tick();
      n_checks++;
      if ({out_valid, out_err, out_data} !== {2'b10, exs[k]})
        $display("FAIL single_result[%0d]: got v=%b e=%b %h want v=1 e=0 %h", k, out_valid, out_err, out_data, exs[k]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_stream();
    logic [CW-1:0] start;
    logic [CW-1:0] diff;
    start = done_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_op(1'b1, 6'b000010, i[4:0], $urandom, RT);
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h00000001})
      $display("FAIL stream_last: got v=%b %h want v=1 00000001", out_valid, out_data);
    else n_pass++;
    tick();
    diff = done_cnt - start;
    n_checks++; if (diff !== CW'(32)) $display("FAIL stream_count: got %0d want 32", diff); else n_pass++;
  endtask

  task automatic test_backpressure();
    int accepted;
    int nret;
    int budget;
    accepted  = 0;
    nret      = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (accepted < 3) set_op(1'b1, 6'b000000, 5'(accepted + 1), 32'h0, RT);
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
      if (out_valid) begin
        n_checks++;
        if (out_data !== (RT << 1)) $display("FAIL bp_first_hold: got %h want %h", out_data, RT << 1);
        else n_pass++;
      end
      tick();
    end
    n_checks++; if (accepted !== 2) $display("FAIL bp_accepts: got %0d want 2", accepted); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
    out_ready = 1'b1;
    budget = 0;
    while ((nret < 3 || accepted < 3) && budget < 12) begin
      if (accepted < 3) set_op(1'b1, 6'b000000, 5'(accepted + 1), 32'h0, RT);
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
      if (out_valid && out_ready) nret++;
      tick();
      budget++;
    end
    in_valid = 1'b0;
    n_checks++; if (nret !== 3) $display("FAIL bp_drain: got %0d want 3 retires", nret); else n_pass++;
  endtask

  task automatic test_invalid_funct();
    logic [5:0]  fs [3] = '{6'b000000, 6'b100000, 6'b000000};
    logic [4:0]  sas[3] = '{5'd4, 5'd3, 5'd8};
    logic [32:0] res[3];
    int          k;
    int          n;
    int          budget;
    k = 0;
    n = 0;
    budget = 0;
    out_ready = 1'b1;
    while (n < 3 && budget < 12) begin
      if (k < 3) set_op(1'b1, fs[k], sas[k], 32'h12345678, RT);
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) k++;
      if (out_valid && out_ready) begin
        res[n] = {out_err, out_data};
        n++;
      end
      tick();
      budget++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (n !== 3) begin
      $display("FAIL inv_count: got %0d want 3", n);
    end else begin
      n_pass++;
      n_checks++; if (res[0] !== {1'b0, 32'h5F0C3E70}) $display("FAIL inv_first: got %h want 05F0C3E70", res[0]); else n_pass++;
      n_checks++; if (res[1] !== {1'b1, 32'h0}) $display("FAIL inv_middle: got %h want 100000000", res[1]); else n_pass++;
      n_checks++; if (res[2] !== {1'b0, 32'hF0C3E700}) $display("FAIL inv_last: got %h want 0F0C3E700", res[2]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_op(1'b1, 6'b000011, 5'd1, 32'h0, RT);
    tick();
    set_op(1'b1, 6'b000010, 5'd2, 32'h0, RT);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b10) $display("FAIL mid_full: got v=%b r=%b want v=1 r=0", out_valid, in_ready);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (done_cnt !== '0) $display("FAIL mid_rst_cnt: got %0d want 0", done_cnt); else n_pass++;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_stale[%0d]: got %b want 0", i, out_valid); else n_pass++;
    end
    set_op(1'b1, 6'b000000, 5'd4, 32'h0, RT);
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h5F0C3E70})
      $display("FAIL mid_next: got v=%b %h want v=1 5F0C3E70", out_valid, out_data);
    else n_pass++;
    tick();
    n_checks++; if (done_cnt !== CW'(1)) $display("FAIL mid_next_cnt: got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] ft[6] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111};
    int         r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 7);
      set_op($urandom_range(0, 3) != 0, (r < 6) ? ft[r] : 6'($urandom), 5'($urandom),
             $urandom, $urandom);
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    n_checks++; if (sb.size() !== 0) $display("FAIL rand_drain: got %0d pending want 0", sb.size()); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_ops();
    test_stream();
    test_backpressure();
    test_invalid_funct();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
